// File: rtl/branch_flag_gen.sv
// rtl/branch_flag_gen.sv - ID-stage branch operand forwarding, flag generation and ID/EX branch register
//
// Purpose:
//   Picks the branch source operand (register file, EX/MEM or MEM/WB forward),
//   derives zero/positive/negative flags from it, detects read-after-write
//   hazards on it, and registers flags plus branch controls into ID/EX.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   id_valid/id_branch/id_jump   ID instruction qualifiers
//   id_brType                    condition code (00 EQZ, 01 NEZ, 10 LTZ, 11 GEZ)
//   id_rsNum/id_rsData           branch source register number and RF data
//   idex_regWrite/idex_rdNum     producer currently in EX
//   exmem_*                      producer currently in MEM (result, load flag)
//   memwb_*                      producer currently in WB (writeback value)
//   ext_stall                    hold ID/EX
//   flush                        squash ID/EX
//   hazStall                     combinational stall request for PC and IF/ID
//   valid_IDEX..flag_IDEX        registered branch controls and flags
//   stallCount                   saturating count of hazard bubbles inserted

module branch_flag_gen #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_branch,
    input  logic              id_jump,
    input  logic [1:0]        id_brType,
    input  logic [REG_W-1:0]  id_rsNum,
    input  logic [DATA_W-1:0] id_rsData,
    input  logic              idex_regWrite,
    input  logic [REG_W-1:0]  idex_rdNum,
    input  logic              exmem_regWrite,
    input  logic              exmem_memRead,
    input  logic [REG_W-1:0]  exmem_rdNum,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_regWrite,
    input  logic [REG_W-1:0]  memwb_rdNum,
    input  logic [DATA_W-1:0] memwb_result,
    input  logic              ext_stall,
    input  logic              flush,
    output logic              hazStall,
    output logic              valid_IDEX,
    output logic              Branch_IDEX,
    output logic              Jump_IDEX,
    output logic [1:0]        branchType_IDEX,
    output logic [2:0]        flag_IDEX,
    output logic [15:0]       stallCount
);

    logic              usesRs;
    logic              exHazard;
    logic              loadHazard;
    logic              hazard;
    logic              fwdExmem;
    logic              fwdMemwb;
    logic [DATA_W-1:0] op;
    logic              zeroFlag;
    logic              negFlag;
    logic              posFlag;
    logic [2:0]        flagNext;

    // Only conditional branches read rs in ID; jumps never stall.
    assign usesRs = id_valid & id_branch;

    // EX producer has no result yet; a load in MEM has no data yet.
    assign exHazard   = idex_regWrite & (idex_rdNum == id_rsNum);
    assign loadHazard = exmem_regWrite & exmem_memRead & (exmem_rdNum == id_rsNum);
    assign hazard     = usesRs & (exHazard | loadHazard);

    // A flushed ID instruction is discarded, so it has nothing to wait for.
    assign hazStall = hazard & ~flush;

    // The younger producer (EX/MEM) wins over MEM/WB; loads in MEM cannot forward.
    assign fwdExmem = exmem_regWrite & ~exmem_memRead & (exmem_rdNum == id_rsNum);
    assign fwdMemwb = memwb_regWrite & (memwb_rdNum == id_rsNum);

    always_comb begin
        op = id_rsData;
        if (fwdExmem) begin
            op = exmem_result;
        end else if (fwdMemwb) begin
            op = memwb_result;
        end
    end

    // One-hot by construction: zero, positive nonzero, or negative.
    assign zeroFlag = (op == '0);
    assign negFlag  = op[DATA_W-1];
    assign posFlag  = ~zeroFlag & ~negFlag;
    assign flagNext = {negFlag, posFlag, zeroFlag};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_IDEX      <= 1'b0;
            Branch_IDEX     <= 1'b0;
            Jump_IDEX       <= 1'b0;
            branchType_IDEX <= 2'b00;
            flag_IDEX       <= 3'b000;
            stallCount      <= 16'd0;
        end else if (flush) begin
            valid_IDEX      <= 1'b0;
            Branch_IDEX     <= 1'b0;
            Jump_IDEX       <= 1'b0;
            branchType_IDEX <= 2'b00;
            flag_IDEX       <= 3'b000;
        end else if (!ext_stall) begin
            if (hazStall) begin
                valid_IDEX      <= 1'b0;
                Branch_IDEX     <= 1'b0;
                Jump_IDEX       <= 1'b0;
                branchType_IDEX <= 2'b00;
                flag_IDEX       <= 3'b000;
                if (stallCount != 16'hFFFF) begin
                    stallCount <= stallCount + 16'd1;
                end
            end else begin
                valid_IDEX      <= id_valid;
                Branch_IDEX     <= id_valid & id_branch;
                Jump_IDEX       <= id_valid & id_jump;
                branchType_IDEX <= id_brType;
                flag_IDEX       <= flagNext;
            end
        end
        // ext_stall without flush: every register holds.
    end

endmodule

// File: tb/tb_branch_flag_gen.sv
// tb/tb_branch_flag_gen.sv - table-driven self-checking bench for branch_flag_gen

module tb_branch_flag_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_branch, id_jump;
    logic [1:0]  id_brType;
    logic [2:0]  id_rsNum;
    logic [15:0] id_rsData;
    logic        idex_regWrite;
    logic [2:0]  idex_rdNum;
    logic        exmem_regWrite, exmem_memRead;
    logic [2:0]  exmem_rdNum;
    logic [15:0] exmem_result;
    logic        memwb_regWrite;
    logic [2:0]  memwb_rdNum;
    logic [15:0] memwb_result;
    logic        ext_stall, flush;
    logic        hazStall;
    logic        valid_IDEX, Branch_IDEX, Jump_IDEX;
    logic [1:0]  branchType_IDEX;
    logic [2:0]  flag_IDEX;
    logic [15:0] stallCount;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_flag_gen #(.DATA_W(16), .REG_W(3)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_branch(id_branch), .id_jump(id_jump),
        .id_brType(id_brType), .id_rsNum(id_rsNum), .id_rsData(id_rsData),
        .idex_regWrite(idex_regWrite), .idex_rdNum(idex_rdNum),
        .exmem_regWrite(exmem_regWrite), .exmem_memRead(exmem_memRead),
        .exmem_rdNum(exmem_rdNum), .exmem_result(exmem_result),
        .memwb_regWrite(memwb_regWrite), .memwb_rdNum(memwb_rdNum),
        .memwb_result(memwb_result),
        .ext_stall(ext_stall), .flush(flush),
        .hazStall(hazStall),
        .valid_IDEX(valid_IDEX), .Branch_IDEX(Branch_IDEX), .Jump_IDEX(Jump_IDEX),
        .branchType_IDEX(branchType_IDEX), .flag_IDEX(flag_IDEX),
        .stallCount(stallCount)
    );

    // outs = {valid, Branch, Jump, type[1:0], flag[2:0]}
    typedef struct {
        logic        v, b, j;
        logic [1:0]  ty;
        logic [2:0]  rs;
        logic [15:0] rsd;
        logic        iw;
        logic [2:0]  ird;
        logic        ew, emr;
        logic [2:0]  erd;
        logic [15:0] eres;
        logic        ww;
        logic [2:0]  wrd;
        logic [15:0] wres;
        logic        stl, fl;
        logic        expHaz;
        logic [7:0]  expOut;
        logic [15:0] expCnt;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [7:0] outs();
        return {valid_IDEX, Branch_IDEX, Jump_IDEX, branchType_IDEX, flag_IDEX};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        id_valid       = x.v;   id_branch     = x.b;   id_jump     = x.j;
        id_brType      = x.ty;  id_rsNum      = x.rs;  id_rsData   = x.rsd;
        idex_regWrite  = x.iw;  idex_rdNum    = x.ird;
        exmem_regWrite = x.ew;  exmem_memRead = x.emr; exmem_rdNum = x.erd;
        exmem_result   = x.eres;
        memwb_regWrite = x.ww;  memwb_rdNum   = x.wrd; memwb_result = x.wres;
        ext_stall      = x.stl; flush         = x.fl;
    endtask

    vec_t h;

    initial begin
        //            v  b  j  ty    rs    rsd       iw ird   ew emr erd  eres      ww wrd  wres     stl fl  haz out           cnt
        vecs[0]  = '{1, 1, 0, 2'b00, 3'd2, 16'h0000, 0, 3'd0, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 0, 8'b110_00_001, 16'd0};
        vecs[1]  = '{1, 1, 0, 2'b10, 3'd2, 16'h8001, 0, 3'd0, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 0, 8'b110_10_100, 16'd0};
        vecs[2]  = '{1, 1, 0, 2'b11, 3'd2, 16'h0005, 0, 3'd0, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 0, 8'b110_11_010, 16'd0};
        vecs[3]  = '{1, 1, 0, 2'b00, 3'd2, 16'h0000, 1, 3'd2, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 1, 8'b000_00_000, 16'd1};
        vecs[4]  = '{1, 1, 0, 2'b00, 3'd2, 16'h0000, 0, 3'd0, 1, 0, 3'd2, 16'hFFFF, 0, 3'd0, 16'h0000, 0, 0, 0, 8'b110_00_100, 16'd1};
        vecs[5]  = '{1, 1, 0, 2'b00, 3'd3, 16'h0005, 0, 3'd0, 1, 1, 3'd3, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 1, 8'b000_00_000, 16'd2};
        vecs[6]  = '{1, 1, 0, 2'b00, 3'd3, 16'h0005, 0, 3'd0, 0, 0, 3'd0, 16'h0000, 1, 3'd3, 16'h0000, 0, 0, 0, 8'b110_00_001, 16'd2};
        vecs[7]  = '{1, 1, 0, 2'b00, 3'd4, 16'h0000, 0, 3'd0, 1, 0, 3'd4, 16'h0007, 1, 3'd4, 16'h0000, 0, 0, 0, 8'b110_00_010, 16'd2};
        vecs[8]  = '{1, 1, 0, 2'b00, 3'd4, 16'h0000, 1, 3'd4, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 1, 0, 8'b000_00_000, 16'd2};
        vecs[9]  = '{1, 0, 1, 2'b01, 3'd1, 16'h8000, 1, 3'd1, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 0, 8'b101_01_100, 16'd2};
        vecs[10] = '{1, 1, 0, 2'b10, 3'd5, 16'h0000, 1, 3'd5, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 1, 8'b101_01_100, 16'd2};
        vecs[11] = '{1, 1, 0, 2'b10, 3'd5, 16'h0000, 1, 3'd5, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 1, 8'b101_01_100, 16'd2};
        vecs[12] = '{1, 1, 0, 2'b10, 3'd5, 16'h0000, 1, 3'd5, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 1, 8'b101_01_100, 16'd2};
        vecs[13] = '{1, 1, 0, 2'b00, 3'd0, 16'h0000, 0, 3'd0, 1, 0, 3'd0, 16'h0003, 0, 3'd0, 16'h0000, 0, 0, 0, 8'b110_00_010, 16'd2};
        vecs[14] = '{1, 1, 0, 2'b00, 3'd5, 16'hFFFF, 1, 3'd6, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 0, 8'b110_00_100, 16'd2};
        vecs[15] = '{1, 1, 0, 2'b00, 3'd5, 16'h0001, 0, 3'd0, 0, 1, 3'd5, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 0, 8'b110_00_010, 16'd2};

        h = '{0, 0, 0, 2'b00, 3'd0, 16'h0000, 0, 3'd0, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 0, 8'h00, 16'd0};
        drive(h);
        rst = 1'b1;
        #1;
        check("reset_outs", {24'd0, outs()}, 32'd0);
        check("reset_count", {16'd0, stallCount}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("vec%0d_hazStall", i), {31'd0, hazStall}, {31'd0, vecs[i].expHaz});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_outs", i), {24'd0, outs()}, {24'd0, vecs[i].expOut});
            check($sformatf("vec%0d_count", i), {16'd0, stallCount}, {16'd0, vecs[i].expCnt});
        end

        // id_valid=0 with a matching producer: no stall, no valid/branch/jump.
        @(negedge clk);
        h = vecs[10]; h.v = 1'b0; h.stl = 1'b0;
        drive(h);
        #1;
        check("novalid_hazStall", {31'd0, hazStall}, 32'd0);
        @(posedge clk);
        #1;
        check("novalid_ctrl", {29'd0, valid_IDEX, Branch_IDEX, Jump_IDEX}, 32'd0);
        check("novalid_count", {16'd0, stallCount}, 32'd2);

        // A producer lingering in EX stalls on consecutive cycles.
        h = vecs[3]; h.rs = 3'd6; h.ird = 3'd6;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(h);
            @(posedge clk);
            #1;
            check($sformatf("repeat%0d_count", k), {16'd0, stallCount}, 32'd3 + k);
            check($sformatf("repeat%0d_valid", k), {31'd0, valid_IDEX}, 32'd0);
        end

        // Load a live value, then reset asynchronously in mid-cycle.
        @(negedge clk);
        drive(vecs[2]);
        @(posedge clk);
        #1;
        check("prereset_outs", {24'd0, outs()}, {24'd0, 8'b110_11_010});
        @(negedge clk);
        drive(h);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outs", {24'd0, outs()}, 32'd0);
        check("async_reset_count", {16'd0, stallCount}, 32'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_count", {16'd0, stallCount}, 32'd1);

        // flush outranks ext_stall: bubble loaded even while stalled.
        @(negedge clk);
        drive(vecs[2]);
        @(posedge clk);
        #1;
        check("preflush_outs", {24'd0, outs()}, {24'd0, 8'b110_11_010});
        @(negedge clk);
        h = vecs[3]; h.fl = 1'b1; h.stl = 1'b1;
        drive(h);
        #1;
        check("flush_stall_hazStall", {31'd0, hazStall}, 32'd0);
        @(posedge clk);
        #1;
        check("flush_stall_outs", {24'd0, outs()}, 32'd0);
        check("flush_stall_count", {16'd0, stallCount}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_flag_gen.md
Name: branch_flag_gen

Overview:
- ID-stage producer of the branch flag vector and branch controls consumed in EX by the branch-decision logic.
- Selects the branch source operand: register file, EX/MEM forward, or MEM/WB forward.
- Computes the zero, positive and negative flags from that operand and detects read-after-write hazards on it.
- Registers flags and controls into the ID/EX pipeline register, with bubble, hold and flush handling.

Parameters:
DATA_W, 16, operand width
REG_W, 3, register-number width

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
id_valid  input  1  ID holds a real instruction
id_branch  input  1  ID instruction is a conditional branch
id_jump  input  1  ID instruction is an unconditional jump
id_brType  input  2  branch condition code (00 EQZ, 01 NEZ, 10 LTZ, 11 GEZ)
id_rsNum  input  REG_W  branch source register number
id_rsData  input  DATA_W  register-file read data for rs
idex_regWrite  input  1  instruction now in EX writes a register
idex_rdNum  input  REG_W  its destination
exmem_regWrite  input  1  instruction in MEM writes a register
exmem_memRead  input  1  instruction in MEM is a load
exmem_rdNum  input  REG_W  its destination
exmem_result  input  DATA_W  its ALU result
memwb_regWrite  input  1  instruction in WB writes a register
memwb_rdNum  input  REG_W  its destination
memwb_result  input  DATA_W  its writeback value
ext_stall  input  1  downstream stall; hold ID/EX
flush  input  1  squash ID/EX (branch taken / jump)
hazStall  output  1  combinational; stall PC and IF/ID this cycle
valid_IDEX  output  1  registered valid
Branch_IDEX  output  1  registered branch
Jump_IDEX  output  1  registered jump
branchType_IDEX  output  2  registered condition code
flag_IDEX  output  3  registered flags: [0] zero, [1] positive nonzero, [2] negative
stallCount  output  16  saturating count of hazard-stall cycles

Behaviour:
- Reset (async, rst=1): valid_IDEX, Branch_IDEX and Jump_IDEX are 0. branchType_IDEX is 00. flag_IDEX is 000. stallCount is 0.
- uses_rs = id_valid & id_branch. Jumps never create hazards.
- Hazard, checked combinationally each cycle: uses_rs and any of:
  - idex_regWrite & idex_rdNum==id_rsNum (result not yet computed);
  - exmem_regWrite & exmem_memRead & exmem_rdNum==id_rsNum (load data not yet available).
- hazStall = hazard & ~flush. A flush cancels the hazard because the ID instruction is squashed.
- Forward select for operand op, evaluated in priority order:
  - exmem_regWrite & ~exmem_memRead & exmem_rdNum==id_rsNum: op = exmem_result;
  - else memwb_regWrite & memwb_rdNum==id_rsNum: op = memwb_result;
  - else op = id_rsData.
- Register 0 receives no special treatment.
- Flags from op:
  - zero = (op==0);
  - neg = op[DATA_W-1];
  - pos = ~zero & ~neg.
  - Exactly one flag bit is set for any operand.
- ID/EX update on posedge clk, in priority order:
  1. flush: load a bubble (valid, Branch and Jump are 0; flags 000; type 00).
  2. ext_stall: hold all registers.
  3. hazStall: load a bubble. stallCount increments and saturates at 0xFFFF.
  4. otherwise load:
     - valid_IDEX = id_valid;
     - Branch_IDEX = id_valid & id_branch;
     - Jump_IDEX = id_valid & id_jump;
     - branchType_IDEX = id_brType;
     - flag_IDEX = computed flags.
- With ext_stall=1 and a hazard present, hazStall is still asserted, stallCount does not increment, and the registers hold.
- stallCount increments only when a bubble is actually inserted for a hazard.
- Latency: flags appear on flag_IDEX one cycle after a non-stalled ID cycle.
- Each load-use or EX-producer hazard costs exactly one bubble. The next cycle the producer has advanced and is forwarded.
- If id_valid=0, hazStall=0 and the register loads a bubble-equivalent.
- Reset asserted mid-stall clears the registers immediately, without waiting for a clock edge.

Test Plan:
- Reset: rst pulse mid-run -> all outputs 0 immediately, stallCount=0.
- No hazard: id_branch=1, rsNum=2, rsData=0x0000 -> next cycle valid_IDEX=1, Branch_IDEX=1, flag_IDEX=001. With rsData=0x8001 -> 100. With 0x0005 -> 010.
- EX-producer hazard:
  - idex_regWrite=1, idex_rdNum=2, branch on r2 -> hazStall=1, next cycle bubble (valid_IDEX=0), stallCount=1.
  - Following cycle exmem_result=0xFFFF with rdNum=2 forwarded -> flag_IDEX=100.
- Load-use: exmem_memRead=1, exmem_regWrite=1, rdNum=3, branch on r3 -> one bubble. Then memwb_result=0 forwards -> flag_IDEX=001.
- Forward priority: EX/MEM writes r4=0x0007 and MEM/WB writes r4=0x0000 -> flag_IDEX=010, showing EX/MEM wins.
- Flush and ext_stall interaction:
  - flush=1 with hazard -> hazStall=0, bubble loaded, stallCount unchanged.
  - ext_stall=1 for 3 cycles -> outputs held, stallCount unchanged.
